// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: IF stage. Owns the fetch PC and issues one aligned 64-bit
// instruction-pair request per cycle. It also drives the IF->ID bus and applies
// flush and branch redirects, including a branch that arrives under a PC stall.
module fetch_pc_unit #(
  parameter logic [31:0]   RESET_PC    = 32'hBFC0_0000,
  parameter int unsigned   STALL_W     = 6,
  localparam int unsigned  BR_WD       = 33,
  localparam int unsigned  IF_TO_ID_WD = 34
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [STALL_W-1:0]     i_stall,
  input  logic                   i_flush,
  input  logic [31:0]            i_new_pc,
  input  logic [BR_WD-1:0]       i_br_bus,
  output logic [IF_TO_ID_WD-1:0] o_if_to_id_bus,
  output logic                   o_inst_sram_en,
  output logic [7:0]             o_inst_sram_wen,
  output logic [31:0]            o_inst_sram_addr,
  output logic [63:0]            o_inst_sram_wdata
);

  localparam logic [31:0] ALIGN_MASK   = ~32'h0000_0007;
  localparam logic [31:0] PC_STEP      = 32'd8;
  // Seeded one pair below the reset PC so the first sequential step lands on it.
  localparam logic [31:0] PC_PRE_RESET = (RESET_PC & ALIGN_MASK) - PC_STEP;

  typedef enum logic [1:0] {
    ST_RST_WAIT   = 2'd0,
    ST_RUN        = 2'd1,
    ST_REDIR_PEND = 2'd2
  } state_t;

  typedef struct packed {
    logic        discard;
    logic        ce;
    logic [31:0] pc;
  } if_to_id_t;

  state_t      r_state;
  logic        r_ce;
  logic [31:0] r_pc;
  logic        r_pend_valid;
  logic [31:0] r_pend_target;

  state_t      w_state_n;
  logic        w_ce_n;
  logic [31:0] w_pc_n;
  logic        w_pend_valid_n;
  logic [31:0] w_pend_target_n;

  logic        w_br_taken;
  logic [31:0] w_br_target;
  logic        w_pc_stall;
  logic [31:0] w_seq_pc;
  if_to_id_t   w_bus;
  logic        w_unused_stall;

  assign w_br_taken     = i_br_bus[32];
  assign w_br_target    = i_br_bus[31:0];
  assign w_pc_stall     = i_stall[0];
  assign w_seq_pc       = r_pc + PC_STEP;
  // Only bit 0 of the stall vector matters to the fetch PC.
  assign w_unused_stall = ^i_stall;

  // State and PC registers, asynchronously reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_RST_WAIT;
      r_ce          <= 1'b0;
      r_pc          <= PC_PRE_RESET;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else begin
      r_state       <= w_state_n;
      r_ce          <= w_ce_n;
      r_pc          <= w_pc_n;
      r_pend_valid  <= w_pend_valid_n;
      r_pend_target <= w_pend_target_n;
    end
  end

  // Next-state / next-PC: flush > pending branch > live branch > sequential.
  always_comb begin
    w_state_n       = r_state;
    w_ce_n          = r_ce;
    w_pc_n          = r_pc;
    w_pend_valid_n  = r_pend_valid;
    w_pend_target_n = r_pend_target;

    unique case (r_state)
      ST_RST_WAIT: begin
        w_state_n = ST_RUN;
        w_ce_n    = 1'b1;
        w_pc_n    = w_seq_pc;
      end

      ST_RUN: begin
        if (i_flush) begin
          w_pc_n = i_new_pc & ALIGN_MASK;
        end else if (!w_pc_stall) begin
          w_pc_n = w_br_taken ? (w_br_target & ALIGN_MASK) : w_seq_pc;
        end else if (w_br_taken) begin
          w_state_n       = ST_REDIR_PEND;
          w_pend_valid_n  = 1'b1;
          w_pend_target_n = w_br_target;
        end
      end

      ST_REDIR_PEND: begin
        // Later branch pulses are ignored; the first latched target wins.
        if (i_flush) begin
          w_pc_n         = i_new_pc & ALIGN_MASK;
          w_pend_valid_n = 1'b0;
          w_state_n      = ST_RUN;
        end else if (!w_pc_stall) begin
          w_pc_n         = r_pend_target & ALIGN_MASK;
          w_pend_valid_n = 1'b0;
          w_state_n      = ST_RUN;
        end
      end

      default: begin
        w_state_n = ST_RST_WAIT;
      end
    endcase
  end

  // IF->ID bus; discard follows br_bus/flush combinationally.
  always_comb begin
    w_bus.ce      = r_ce;
    w_bus.pc      = r_ce ? r_pc : 32'h0;
    w_bus.discard = r_ce & ~i_flush & (w_br_taken | r_pend_valid);
  end

  assign o_if_to_id_bus    = w_bus;
  assign o_inst_sram_en    = r_ce;
  assign o_inst_sram_addr  = r_ce ? r_pc : 32'h0;
  assign o_inst_sram_wen   = 8'h00;
  assign o_inst_sram_wdata = 64'h0;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Testbench for fetch_pc_unit: scenario tasks push expected bus values into a
// scoreboard queue as they drive each cycle and pop/compare at the negedge.
`timescale 1ns/1ps
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [32:0] br_bus;
  logic [33:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [7:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [63:0] inst_sram_wdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [33:0] sb_q[$];

  fetch_pc_unit #(.RESET_PC(32'hBFC0_0000), .STALL_W(6)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_stall           (stall),
    .i_flush           (flush),
    .i_new_pc          (new_pc),
    .i_br_bus          (br_bus),
    .o_if_to_id_bus    (if_to_id_bus),
    .o_inst_sram_en    (inst_sram_en),
    .o_inst_sram_wen   (inst_sram_wen),
    .o_inst_sram_addr  (inst_sram_addr),
    .o_inst_sram_wdata (inst_sram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic s0, input logic fl, input logic [31:0] np,
                       input logic tk, input logic [31:0] tgt);
    stall  = {5'b0, s0};
    flush  = fl;
    new_pc = np;
    br_bus = {tk, tgt};
  endtask

  task automatic test_reset();
    logic [33:0] exp;
    logic [31:0] pcs [3] = '{32'hBFC0_0000, 32'hBFC0_0008, 32'hBFC0_0010};
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    sb_q.push_back(34'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp = sb_q.pop_front();
    n_checks++;
    if (if_to_id_bus !== exp) begin
      n_errors++; $display("FAIL reset_bus got %h want %h", if_to_id_bus, exp);
    end
    n_checks++;
    if ({inst_sram_en, inst_sram_addr} !== 33'h0) begin
      n_errors++; $display("FAIL reset_sram got en=%b addr=%h want 0", inst_sram_en, inst_sram_addr);
    end
    n_checks++;
    if ({inst_sram_wen, inst_sram_wdata} !== 72'h0) begin
      n_errors++; $display("FAIL tie_offs got wen=%h wdata=%h want 0", inst_sram_wen, inst_sram_wdata);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      sb_q.push_back({1'b0, 1'b1, pcs[i]});
      @(negedge clk);
      exp = sb_q.pop_front();
      n_checks++;
      if (if_to_id_bus !== exp || inst_sram_addr !== exp[31:0] || inst_sram_en !== 1'b1) begin
        n_errors++; $display("FAIL release_%0d got bus=%h addr=%h en=%b want bus=%h", i, if_to_id_bus, inst_sram_addr, inst_sram_en, exp);
      end
    end
  endtask

  task automatic test_branch();
    logic [33:0] exp;
    logic        tk  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic        dsc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] pcs [4] = '{32'hBFC0_0018, 32'hBFC0_0020, 32'hBFC0_0100, 32'hBFC0_0108};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 32'h0, tk[i], 32'hBFC0_0104);
      sb_q.push_back({dsc[i], 1'b1, pcs[i]});
      @(negedge clk);
      exp = sb_q.pop_front();
      n_checks++;
      if (if_to_id_bus !== exp || inst_sram_addr !== exp[31:0]) begin
        n_errors++; $display("FAIL branch_%0d got bus=%h addr=%h want %h", i, if_to_id_bus, inst_sram_addr, exp);
      end
    end
  endtask

  task automatic test_stall_branch();
    logic [33:0] exp;
    logic        s0  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        tk  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] tg  [5] = '{32'h8000_0010, 32'h9000_0000, 32'h0, 32'h0, 32'h0};
    logic        dsc [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] pcs [5] = '{32'hBFC0_0110, 32'hBFC0_0110, 32'hBFC0_0110, 32'hBFC0_0110, 32'h8000_0010};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(s0[i], 1'b0, 32'h0, tk[i], tg[i]);
      sb_q.push_back({dsc[i], 1'b1, pcs[i]});
      @(negedge clk);
      exp = sb_q.pop_front();
      n_checks++;
      if (if_to_id_bus !== exp || inst_sram_addr !== exp[31:0]) begin
        n_errors++; $display("FAIL stall_br_%0d got bus=%h addr=%h want %h", i, if_to_id_bus, inst_sram_addr, exp);
      end
      if (i == 1 || i == 2) begin
        n_checks++;
        if (2'(dut.r_state) !== 2'd2) begin
          n_errors++; $display("FAIL stall_br_state_%0d got %0d want 2", i, 2'(dut.r_state));
        end
      end
    end
    n_checks++;
    if (dut.r_pend_valid !== 1'b0 || 2'(dut.r_state) !== 2'd1) begin
      n_errors++; $display("FAIL stall_br_release got pend=%b state=%0d want 0/1", dut.r_pend_valid, 2'(dut.r_state));
    end
  endtask

  task automatic test_flush_priority();
    logic [33:0] exp;
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 32'hBFC0_0380, 1'b1, 32'h1234_5678);
    sb_q.push_back({1'b0, 1'b1, 32'h8000_0018});
    @(negedge clk);
    exp = sb_q.pop_front();
    n_checks++;
    if (if_to_id_bus !== exp) begin
      n_errors++; $display("FAIL flush_same_cycle got %h want %h", if_to_id_bus, exp);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    sb_q.push_back({1'b0, 1'b1, 32'hBFC0_0380});
    @(negedge clk);
    exp = sb_q.pop_front();
    n_checks++;
    if (if_to_id_bus !== exp || dut.r_pend_valid !== 1'b0) begin
      n_errors++; $display("FAIL flush_next got bus=%h pend=%b want %h pend=0", if_to_id_bus, dut.r_pend_valid, exp);
    end
  endtask

  task automatic test_flush_pending();
    logic [33:0] exp;
    logic        s0  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        fl  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        tk  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        dsc [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] pcs [5] = '{32'hBFC0_0388, 32'hBFC0_0388, 32'hBFC0_0388, 32'hBFC0_0380, 32'hBFC0_0388};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(s0[i], fl[i], 32'hBFC0_0384, tk[i], 32'h8000_0040);
      sb_q.push_back({dsc[i], 1'b1, pcs[i]});
      @(negedge clk);
      exp = sb_q.pop_front();
      n_checks++;
      if (if_to_id_bus !== exp || inst_sram_addr !== exp[31:0]) begin
        n_errors++; $display("FAIL flush_pend_%0d got bus=%h addr=%h want %h", i, if_to_id_bus, inst_sram_addr, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [33:0] exp;
    logic        fl  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] pcs [4] = '{32'hBFC0_0390, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0008};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(1'b0, fl[i], 32'hFFFF_FFFF, 1'b0, 32'h0);
      sb_q.push_back({1'b0, 1'b1, pcs[i]});
      @(negedge clk);
      exp = sb_q.pop_front();
      n_checks++;
      if (if_to_id_bus !== exp || inst_sram_addr !== exp[31:0] || inst_sram_en !== 1'b1) begin
        n_errors++; $display("FAIL wrap_%0d got bus=%h addr=%h en=%b want %h", i, if_to_id_bus, inst_sram_addr, inst_sram_en, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] exp;
    logic        s0  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        tk  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] tg  [6] = '{32'h0000_1000, 32'h0000_2004, 32'h0, 32'h0, 32'h0, 32'h0};
    logic        dsc [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] pcs [6] = '{32'h0000_0010, 32'h0000_1000, 32'h0000_2000, 32'h0000_2008, 32'h0000_2008, 32'h0000_2010};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      drive(s0[i], 1'b0, 32'h0, tk[i], tg[i]);
      sb_q.push_back({dsc[i], 1'b1, pcs[i]});
      @(negedge clk);
      exp = sb_q.pop_front();
      n_checks++;
      if (if_to_id_bus !== exp || inst_sram_addr !== exp[31:0]) begin
        n_errors++; $display("FAIL b2b_%0d got bus=%h addr=%h want %h", i, if_to_id_bus, inst_sram_addr, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [33:0] exp;
    logic [31:0] pcs [2] = '{32'h0000_2018, 32'h0000_2018};
    logic        tk  [2] = '{1'b1, 1'b0};
    logic [31:0] rpc [2] = '{32'hBFC0_0000, 32'hBFC0_0008};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 32'h0, tk[i], 32'h8000_0010);
      sb_q.push_back({1'b1, 1'b1, pcs[i]});
      @(negedge clk);
      exp = sb_q.pop_front();
      n_checks++;
      if (if_to_id_bus !== exp) begin
        n_errors++; $display("FAIL arst_pre_%0d got %h want %h", i, if_to_id_bus, exp);
      end
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (if_to_id_bus !== 34'h0 || inst_sram_en !== 1'b0 || inst_sram_addr !== 32'h0) begin
      n_errors++; $display("FAIL arst_outputs got bus=%h en=%b addr=%h want 0", if_to_id_bus, inst_sram_en, inst_sram_addr);
    end
    n_checks++;
    if (2'(dut.r_state) !== 2'd0 || dut.r_pend_valid !== 1'b0 || dut.r_pc !== 32'hBFBF_FFF8) begin
      n_errors++; $display("FAIL arst_state got state=%0d pend=%b pc=%h want 0/0/bfbffff8", 2'(dut.r_state), dut.r_pend_valid, dut.r_pc);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      sb_q.push_back({1'b0, 1'b1, rpc[i]});
      @(negedge clk);
      exp = sb_q.pop_front();
      n_checks++;
      if (if_to_id_bus !== exp || inst_sram_addr !== exp[31:0]) begin
        n_errors++; $display("FAIL arst_restart_%0d got bus=%h addr=%h want %h", i, if_to_id_bus, inst_sram_addr, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_stall_branch();
    test_flush_priority();
    test_flush_pending();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch (IF) stage of the dual-issue core, and the producer of the IF→ID interface. It owns the fetch PC and issues one 64-bit, 8-byte-aligned instruction-pair request to inst SRAM per cycle. It publishes `{discard, ce, pc}` on `if_to_id_bus`, and the decode stage registers that bus alongside the returning `inst_sram_rdata`. It applies branch redirects from `br_bus`, exception redirects from `flush`/`new_pc`, and holds a branch redirect that arrives during a PC stall until the stall releases.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: first fetch address after reset. Must be 8-byte aligned.
- `clk` in 1: core clock.
- `rst` in 1: reset. Asynchronous, active-high.
- `stall` in `StallBus`: stall vector. Bit 0 freezes the PC.
- `flush` in 1: exception/ERET redirect. Highest priority.
- `new_pc` in 32: redirect target, valid while `flush`=1.
- `br_bus` in `BR_WD` (33): {taken[32], target[31:0]} from decode.
- `if_to_id_bus` out `IF_TO_ID_WD` (34): {discard[33], ce[32], pc[31:0]}.
- `inst_sram_en` out 1: fetch request enable.
- `inst_sram_wen` out 8: tied 8'h00.
- `inst_sram_addr` out 32: fetch address, always 8-byte aligned.
- `inst_sram_wdata` out 64: tied 0.

## Operation
- Registers:
  - `pc_reg[31:0]`
  - `ce_reg`
  - `pend_valid`
  - `pend_target[31:0]`
  - 2-bit `state`: RST_WAIT, RUN, REDIR_PEND.
- Reset values (asynchronous):
  - `state`=RST_WAIT, `ce_reg`=0, `pc_reg`=`RESET_PC`−8, `pend_valid`=0, `pend_target`=0.
  - Outputs: `if_to_id_bus`=34'b0, `inst_sram_en`=0, `inst_sram_addr`=0.
- Alignment: every address loaded into `pc_reg` is forced to `addr & ~32'h7`. Decode recovers the exact target by PC matching within the pair.
- Next-PC priority:
  1. `flush` → `new_pc`
  2. `pend_valid` → `pend_target`
  3. `br_bus[32]` → `br_bus[31:0]`
  4. otherwise `pc_reg`+8, mod 2^32 (wrap from 32'hFFFF_FFF8 to 0 is legal).
- `pc_reg` loads next-PC on a clock edge when `flush`=1 or `stall[0]`=0. Otherwise it holds.
- State transitions:
  - RST_WAIT → RUN on the first edge after `rst` deasserts. `ce_reg`←1 and `pc_reg`←`RESET_PC` (the +8 path).
  - RUN → REDIR_PEND when `br_bus[32]`=1, `stall[0]`=1 and `flush`=0. Latch `pend_target`←`br_bus[31:0]`, set `pend_valid`.
  - REDIR_PEND → RUN on the edge where `stall[0]`=0 (PC loads `pend_target`) or `flush`=1 (PC loads `new_pc`). Clear `pend_valid` on either.
  - In REDIR_PEND, further `br_bus[32]` pulses are ignored; the first latched target wins.
- Output mapping:
  - `inst_sram_en` = `ce_reg`.
  - `inst_sram_addr` = `ce_reg` ? `pc_reg` : 0.
  - `if_to_id_bus.ce` = `ce_reg`.
  - `if_to_id_bus.pc` = `ce_reg` ? `pc_reg` : 0. Decode treats pc 0 as invalid.
  - `if_to_id_bus.discard` = `ce_reg` & ~`flush` & (`br_bus[32]` | `pend_valid`). This marks the sequential pair fetched after a resolved branch as not-to-be-enqueued.

## Timing
- Fetch latency: the address is presented in cycle t and the SRAM data returns in t+1. Decode pairs that data with the bus value it registered at the end of t.
- Redirects:
  - Branch with `stall[0]`=0 in cycle t: `pc_reg`=target&~7 in t+1. Exactly one pair, the one at `pc_reg`(t), carries `discard`=1.
  - Branch under stall: `discard`=1 on every cycle until the redirect is applied.
  - Flush in cycle t: `pc_reg`=`new_pc`&~7 in t+1, regardless of `stall`. `discard`=0 in t.
- Simultaneous events: `flush` and `br_bus[32]` in the same cycle → flush wins and the branch is dropped.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). A pending redirect is lost.
- `br_bus` and `flush` paths to the outputs are combinational (no register). `pc_reg`, `ce_reg` and the pending state are registered.

## Test plan
- Reset release, no stall:
  - `inst_sram_en`=0 and bus=0 while `rst`=1.
  - Addresses BFC0_0000, BFC0_0008, BFC0_0010 on consecutive cycles after release; `discard`=0 throughout.
- Taken branch to BFC0_0104 while `pc_reg`=BFC0_0020, no stall:
  - That cycle: bus `discard`=1, pc=BFC0_0020.
  - Next cycle `pc_reg`=BFC0_0100, then BFC0_0108.
- Branch to 8000_0010 with `stall[0]`=1 held 3 cycles:
  - PC frozen and `discard`=1 for all 3 cycles; `state`=REDIR_PEND.
  - After release `pc_reg`=8000_0010 and `pend_valid`=0.
- `flush` with `new_pc`=BFC0_0380, asserted together with `br_bus` taken and `stall[0]`=1:
  - Next `pc_reg`=BFC0_0380, `pend_valid`=0, `discard`=0 that cycle.
- `flush` during REDIR_PEND: pending target discarded; PC takes `new_pc`&~7.
- Wrap: `pc_reg`=FFFF_FFF8, no events → next `pc_reg`=0000_0000, `ce`=1.
- Asynchronous `rst` asserted mid-cycle in REDIR_PEND: outputs drop to 0 before the next edge; on release, fetch restarts at BFC0_0000.
